arith_sequencer: RTL and testbench

Multi-cycle command sequencer that drives the 2-bit-opcode add/increment/subtract/decrement datapath from the controller side. It accepts a command over a valid/ready handshake, optionally loads an internal accumulator, and applies one operation per clock for a programmable repeat count. It then returns the accumulator and sticky flags over a second valid/ready handshake. It sits between a control FSM or bus bridge and the arithmetic datapath. Repeated ADD gives multiply-by-count; repeated DEC gives countdown.

---
 rtl/arith_sequencer_pkg.sv | 18 +
 rtl/arith_sequencer_step.sv | 42 ++++
 rtl/arith_sequencer.sv | 129 ++++++++++++
 tb/tb_arith_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_sequencer_pkg.sv
// Shared encodings for the arithmetic command sequencer.
// Op codes match the existing add/inc/sub/dec datapath.
package arith_sequencer_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    function automatic logic op_is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/arith_sequencer_step.sv
// One combinational accumulator step: acc op B -> {carry, result}.
// ARITH_SEQ_OVF_EN adds the signed-overflow output.
module arith_step
    import arith_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
`ifdef ARITH_SEQ_OVF_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic             sub;

    always_comb begin
        sub  = op_is_sub(op);
        opnd = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        sum  = {1'b0, acc} + {1'b0, opnd};
        dif  = {1'b0, acc} - {1'b0, opnd};
        // top bit of the widened difference is the unsigned borrow
        result = sub ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
        carry  = sub ? dif[WIDTH] : sum[WIDTH];
    end

`ifdef ARITH_SEQ_OVF_EN
    always_comb begin
        overflow = (result[WIDTH-1] != acc[WIDTH-1]) &&
                   (sub ? (acc[WIDTH-1] != opnd[WIDTH-1])
                        : (acc[WIDTH-1] == opnd[WIDTH-1]));
    end
`endif

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle add/inc/sub/dec command sequencer with sticky flags.
// Define ARITH_SEQ_OVF_EN to add the rsp_overflow output.
module arith_sequencer
    import arith_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
`ifdef ARITH_SEQ_OVF_EN
    ,
    output logic             rsp_overflow
`endif
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] step_res;
    logic             step_c;
`ifdef ARITH_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
    logic             step_ovf;
`endif

    arith_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .b       (b_q),
        .op      (op_q),
        .result  (step_res),
        .carry   (step_c)
`ifdef ARITH_SEQ_OVF_EN
        ,
        .overflow(step_ovf)
`endif
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
`ifdef ARITH_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    b_d     = cmd_b;
                    cnt_d   = cmd_count;
                    carry_d = 1'b0;
`ifdef ARITH_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    if (cmd_load) acc_d = cmd_a;
                    state_d = (cmd_count != '0) ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                acc_d   = step_res;
                carry_d = carry_q | step_c;
`ifdef ARITH_SEQ_OVF_EN
                ovf_d   = ovf_q | step_ovf;
`endif
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            carry_q <= 1'b0;
`ifdef ARITH_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
`ifdef ARITH_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_result = acc_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = (acc_q == '0);
`ifdef ARITH_SEQ_OVF_EN
    assign rsp_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed-vector bench for arith_sequencer.
// Honours ARITH_SEQ_OVF_EN for the overflow port.
module tb_arith_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_count;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       busy;
`ifdef ARITH_SEQ_OVF_EN
    logic       rsp_overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arith_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_load  (cmd_load),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
`ifdef ARITH_SEQ_OVF_EN
        ,
        .rsp_overflow(rsp_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command, wait for rsp_valid, check latency and busy.
    task automatic run(input string tag, input logic ld, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] op,
                       input logic [3:0] cnt);
        int  lat;
        logic bz;
        check({tag, ".rdy"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        bz  = busy;
        while (!rsp_valid && lat < 40) begin
            tick();
            bz = bz & busy;
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(cnt));
        check({tag, ".busy"}, 32'(bz), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] res,
                              input logic c, input logic z);
        check({tag, ".res"}, 32'(rsp_result), 32'(res));
        check({tag, ".c"}, 32'(rsp_carry), 32'(c));
        check({tag, ".z"}, 32'(rsp_zero), 32'(z));
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("take.rdy", 32'(cmd_ready), 32'd1);
        check("take.busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_load  = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_count = 4'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst.rdy", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.vld", 32'(rsp_valid), 32'd0);
        expect_rsp("rst", 8'h00, 1'b0, 1'b1);
        check("rst.rdy1", 32'(cmd_ready), 32'd1);

        run("add1", 1'b1, 8'd2, 8'd3, 2'b00, 4'd1);
        expect_rsp("add1", 8'd5, 1'b0, 1'b0);
        take();

        run("mul4", 1'b1, 8'd0, 8'd3, 2'b00, 4'd4);
        expect_rsp("mul4", 8'd12, 1'b0, 1'b0);
        take();

        run("sub", 1'b1, 8'd2, 8'd3, 2'b10, 4'd1);
        expect_rsp("sub", 8'hFF, 1'b1, 1'b0);
        take();

        run("dec2", 1'b0, 8'd0, 8'd0, 2'b11, 4'd2);
        expect_rsp("dec2", 8'hFD, 1'b0, 1'b0);
        take();

        run("incw", 1'b1, 8'hFF, 8'd0, 2'b01, 4'd1);
        expect_rsp("incw", 8'h00, 1'b1, 1'b1);
        take();

        run("decw", 1'b1, 8'h00, 8'd9, 2'b11, 4'd1);
        expect_rsp("decw", 8'hFF, 1'b1, 1'b0);
        take();

`ifdef ARITH_SEQ_OVF_EN
        run("ovf", 1'b1, 8'h7F, 8'd0, 2'b01, 4'd1);
        expect_rsp("ovf", 8'h80, 1'b0, 1'b0);
        check("ovf.v", 32'(rsp_overflow), 32'd1);
        take();
        run("novf", 1'b1, 8'h10, 8'h20, 2'b00, 4'd1);
        check("novf.v", 32'(rsp_overflow), 32'd0);
        take();
`endif

        run("hold", 1'b1, 8'h10, 8'h01, 2'b00, 4'd1);
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_a     = 8'h55;
        cmd_count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold.vld", 32'(rsp_valid), 32'd1);
            check("hold.rdy", 32'(cmd_ready), 32'd0);
            expect_rsp("hold", 8'h11, 1'b0, 1'b0);
        end
        cmd_valid = 1'b0;
        take();

        run("cnt0", 1'b0, 8'h00, 8'h07, 2'b00, 4'd0);
        expect_rsp("cnt0", 8'h11, 1'b0, 1'b0);
        take();

        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_a     = 8'h00;
        cmd_b     = 8'h01;
        cmd_op    = 2'b00;
        cmd_count = 4'd8;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.vld", 32'(rsp_valid), 32'd0);
        check("mrst.rdy", 32'(cmd_ready), 32'd1);

        run("post", 1'b0, 8'h00, 8'h00, 2'b00, 4'd0);
        expect_rsp("post", 8'h00, 1'b0, 1'b1);
        take();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
